// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, address decode bit and frame width.
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } tx_state_e;

   localparam int unsigned UART_ADDR_SEL_BIT = 7;
   localparam int unsigned DATA_BITS         = 8;
   localparam int unsigned BIT_IDX_W         = $clog2(DATA_BITS);

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period counter: runs 0..CLKS_PER_BIT-1 while enabled and flags the last clock of each bit.
module uart_bit_timer #(
   parameter int unsigned CLKS_PER_BIT = 87
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic bit_end_c
);

   localparam int unsigned      CNT_W   = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

   logic [CNT_W-1:0] count;

   assign bit_end_c = enable && (count == CNT_MAX);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable) begin
         count <= bit_end_c ? '0 : count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/uart_transmitter.sv
// APB-attached 8N1 UART transmitter; write accepts a byte, PREADY stalls writes while a frame is in flight.
module uart_transmitter
   import uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 87
) (
   input  logic                 PCLK,
   input  logic                 PRESETn,
   input  logic                 PSEL,
   input  logic                 PENABLE,
   input  logic                 PWRITE,
   input  logic [7:0]           PADDR,
   input  logic [DATA_BITS-1:0] PWDATA,
   output logic [7:0]           PRDATA,
   output logic                 PREADY,
   output logic                 tx_serial,
   output logic                 tx_busy,
   output logic                 tx_done
);

   tx_state_e                state;
   logic [DATA_BITS-1:0]     shift;
   logic [BIT_IDX_W-1:0]     bit_idx;
   logic                     sel_c;
   logic                     accept_c;
   logic                     timer_clear_c;
   logic                     timer_en_c;
   logic                     bit_end_c;

   assign sel_c         = PSEL && PENABLE && PADDR[UART_ADDR_SEL_BIT];
   assign accept_c      = sel_c && PWRITE && (state == IDLE);
   assign timer_clear_c = (state == IDLE);
   assign timer_en_c    = (state != IDLE);

   // Reads always complete at once; writes wait until the transmitter is idle.
   assign PREADY = sel_c && (!PWRITE || (state == IDLE));

   uart_bit_timer #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_bit_timer (
      .clk       (PCLK),
      .rst_n     (PRESETn),
      .clear     (timer_clear_c),
      .enable    (timer_en_c),
      .bit_end_c (bit_end_c)
   );

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state     <= IDLE;
         shift     <= '0;
         bit_idx   <= '0;
         tx_serial <= 1'b1;
         tx_busy   <= 1'b0;
         tx_done   <= 1'b0;
         PRDATA    <= '0;
      end else begin
         tx_done <= 1'b0;
         if (sel_c && !PWRITE) begin
            PRDATA <= {7'b0, tx_busy};
         end
         // tx_serial is registered one step ahead so the line changes exactly on bit boundaries.
         case (state)
            IDLE: begin
               tx_serial <= 1'b1;
               if (accept_c) begin
                  shift     <= PWDATA;
                  bit_idx   <= '0;
                  state     <= START;
                  tx_serial <= 1'b0;
                  tx_busy   <= 1'b1;
               end
            end
            START: begin
               if (bit_end_c) begin
                  state     <= DATA;
                  bit_idx   <= '0;
                  tx_serial <= shift[0];
               end
            end
            DATA: begin
               if (bit_end_c) begin
                  if (bit_idx == BIT_IDX_W'(DATA_BITS - 1)) begin
                     state     <= STOP;
                     tx_serial <= 1'b1;
                  end else begin
                     bit_idx   <= bit_idx + BIT_IDX_W'(1);
                     tx_serial <= shift[bit_idx + BIT_IDX_W'(1)];
                  end
               end
            end
            STOP: begin
               if (bit_end_c) begin
                  state   <= IDLE;
                  tx_busy <= 1'b0;
                  tx_done <= 1'b1;
               end
            end
            default: begin
               state     <= IDLE;
               tx_serial <= 1'b1;
               tx_busy   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_transmitter.sv
// Self-checking bench for uart_transmitter at CLKS_PER_BIT=4 and CLKS_PER_BIT=2.
module tb_uart_transmitter;

   localparam int N4       = 4;
   localparam int N2       = 2;
   localparam int WAIT_MAX = 200;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       psel = 1'b0;
   logic       penable = 1'b0;
   logic       pwrite = 1'b0;
   logic [7:0] paddr = 8'h00;
   logic [7:0] pwdata = 8'h00;

   logic [7:0] prdata4, prdata2;
   logic       pready4, pready2, txs4, txs2, busy4, busy2, done4, done2;

   logic       use2 = 1'b0;
   logic       rdy, txs, busy, done;
   logic [7:0] prd;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   assign rdy  = use2 ? pready2 : pready4;
   assign txs  = use2 ? txs2    : txs4;
   assign busy = use2 ? busy2   : busy4;
   assign done = use2 ? done2   : done4;
   assign prd  = use2 ? prdata2 : prdata4;

   uart_transmitter #(.CLKS_PER_BIT(N4)) dut4 (
      .PCLK(clk), .PRESETn(rst_n), .PSEL(psel), .PENABLE(penable), .PWRITE(pwrite),
      .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata4), .PREADY(pready4),
      .tx_serial(txs4), .tx_busy(busy4), .tx_done(done4)
   );

   uart_transmitter #(.CLKS_PER_BIT(N2)) dut2 (
      .PCLK(clk), .PRESETn(rst_n), .PSEL(psel), .PENABLE(penable), .PWRITE(pwrite),
      .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata2), .PREADY(pready2),
      .tx_serial(txs2), .tx_busy(busy2), .tx_done(done2)
   );

   typedef struct {
      logic       psel;
      logic       penable;
      logic       pwrite;
      logic [7:0] paddr;
      logic [7:0] pwdata;
      logic       exp_ready;
   } vec_t;

   vec_t vecs[8];

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %02h expected %02h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: expected line level k clocks after acceptance for an 8N1 frame of n clocks per bit.
   function automatic logic exp_bit(input logic [7:0] d, input int k, input int n);
      int b;
      b = k / n;
      if (b == 0) return 1'b0;
      if (b >= 9) return 1'b1;
      return d[b-1];
   endfunction

   task automatic do_reset();
      @(posedge clk); #1;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic apb_write(input logic [7:0] addr, input logic [7:0] data, input bit stalled);
      int n;
      @(posedge clk); #1;
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = addr; pwdata = data;
      @(posedge clk); #1;
      penable = 1'b1;
      n = 0;
      @(negedge clk);
      while (!rdy && n < WAIT_MAX) begin
         @(negedge clk);
         n++;
      end
      if (!rdy) begin
         checks++;
         errors++;
         $display("FAIL write_timeout: PREADY still %b after %0d cycles, expected 1", rdy, n);
      end else if (stalled) begin
         chk1("stalled_ready_with_done", done, 1'b1);
         chk1("stalled_ready_waited", logic'(n > 0), 1'b1);
      end else begin
         chk1("write_ready_immediate", logic'(n == 0), 1'b1);
      end
      @(posedge clk); #1;
      psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
   endtask

   task automatic apb_read(input logic [7:0] addr, input logic [7:0] exp);
      @(posedge clk); #1;
      psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = addr;
      @(posedge clk); #1;
      penable = 1'b1;
      @(negedge clk);
      chk1("read_ready", rdy, 1'b1);
      @(posedge clk); #1;
      psel = 1'b0; penable = 1'b0;
      @(negedge clk);
      chk8("read_prdata", prd, exp);
   endtask

   // Starts right after the acceptance edge; ends on the negedge of the tx_done cycle.
   task automatic check_frame(input logic [7:0] d, input int n);
      for (int k = 0; k < 10 * n; k++) begin
         @(negedge clk);
         chk1("frame_serial", txs, exp_bit(d, k, n));
         chk1("frame_busy", busy, 1'b1);
         chk1("frame_done_low", done, 1'b0);
      end
      @(negedge clk);
      chk1("end_serial", txs, 1'b1);
      chk1("end_busy", busy, 1'b0);
      chk1("end_done", done, 1'b1);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [7:0] d;

      vecs[0] = '{1'b1, 1'b1, 1'b1, 8'h00, 8'h55, 1'b0};
      vecs[1] = '{1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0};
      vecs[2] = '{1'b1, 1'b0, 1'b1, 8'h80, 8'hAA, 1'b0};
      vecs[3] = '{1'b0, 1'b1, 1'b1, 8'h80, 8'h11, 1'b0};
      vecs[4] = '{1'b1, 1'b1, 1'b0, 8'h80, 8'h00, 1'b1};
      vecs[5] = '{1'b1, 1'b1, 1'b0, 8'hFF, 8'h00, 1'b1};
      vecs[6] = '{1'b1, 1'b1, 1'b1, 8'h7F, 8'hF0, 1'b0};
      vecs[7] = '{1'b0, 1'b0, 1'b0, 8'h80, 8'h0F, 1'b0};

      // Reset state
      repeat (2) @(negedge clk);
      chk1("rst_serial", txs, 1'b1);
      chk1("rst_busy", busy, 1'b0);
      chk1("rst_done", done, 1'b0);
      chk8("rst_prdata", prd, 8'h00);
      chk1("rst_ready", rdy, 1'b0);
      @(posedge clk); #1 rst_n = 1'b1;

      // Idle-state access table: none of these may start a frame
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         psel = vecs[i].psel; penable = vecs[i].penable; pwrite = vecs[i].pwrite;
         paddr = vecs[i].paddr; pwdata = vecs[i].pwdata;
         @(negedge clk);
         chk1("vec_ready", rdy, vecs[i].exp_ready);
         @(posedge clk); #1;
         psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
         @(negedge clk);
         chk1("vec_busy", busy, 1'b0);
         chk1("vec_serial", txs, 1'b1);
         chk8("vec_prdata", prd, 8'h00);
      end

      // Single frame 0xA5, then a stalled write of 0x3C, with PWDATA disturbed mid-frame
      apb_write(8'h80, 8'hA5, 1'b0);
      pwdata = 8'h5A;
      fork
         check_frame(8'hA5, N4);
         begin
            repeat (12) @(posedge clk);
            apb_write(8'h80, 8'h3C, 1'b1);
            pwdata = 8'hC3;
         end
      join
      check_frame(8'h3C, N4);
      @(negedge clk);
      chk1("done_returns_low", done, 1'b0);

      // Status reads mid-frame and after completion
      apb_write(8'h80, 8'h96, 1'b0);
      fork
         check_frame(8'h96, N4);
         begin
            repeat (6) @(posedge clk);
            apb_read(8'h80, 8'h01);
         end
      join
      apb_read(8'h80, 8'h00);

      // Randomized bytes against the frame model
      for (int i = 0; i < 6; i++) begin
         d = 8'($urandom);
         apb_write(8'h80, d, 1'b0);
         pwdata = 8'($urandom);
         check_frame(d, N4);
         repeat ($urandom_range(0, 3)) @(posedge clk);
      end

      // Async reset during data bit 3 of 0xFF
      apb_write(8'h80, 8'hFF, 1'b0);
      for (int k = 0; k < 18; k++) begin
         @(negedge clk);
         chk1("pre_rst_serial", txs, exp_bit(8'hFF, k, N4));
      end
      #2 rst_n = 1'b0;
      #1;
      chk1("async_rst_serial", txs, 1'b1);
      chk1("async_rst_busy", busy, 1'b0);
      chk1("async_rst_done", done, 1'b0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (3) @(negedge clk);
      chk1("post_rst_serial", txs, 1'b1);
      chk1("post_rst_busy", busy, 1'b0);
      apb_write(8'h80, 8'h00, 1'b0);
      check_frame(8'h00, N4);

      // Minimum bit period, data 0x80
      use2 = 1'b1;
      do_reset();
      @(negedge clk);
      chk1("n2_idle_serial", txs, 1'b1);
      apb_write(8'h80, 8'h80, 1'b0);
      check_frame(8'h80, N2);
      @(negedge clk);
      chk1("n2_done_low", done, 1'b0);
      chk1("n2_idle_after", txs, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
